// File: rtl/int_res_stream_rd_if.sv
// int_res_stream_rd_if: job request, int-res memory read port and output stream of the read streamer.
// Latency: n/a (bundle of signals only).
// Backpressure: out_valid/out_ready handshake on the stream; the memory port has none.
// Ports: master = streamer side (drives reads, stream, status); slave = job source, memory and consumer.
interface int_res_stream_rd_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,   // N_COMP
   parameter int FMT_W  = 3,
   parameter int LEN_W  = 16
);
   // job request / status
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] stride;
   logic [LEN_W-1:0]  len;
   logic              data_width;
   logic [FMT_W-1:0]  format;
   logic              busy;
   logic              done;
   // int-res memory read port
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_data_width;
   logic [FMT_W-1:0]  mem_rd_format;
   logic [DATA_W-1:0] mem_rd_data;
   // output stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      input  start, base_addr, stride, len, data_width, format, mem_rd_data, out_ready,
      output busy, done, mem_rd_en, mem_rd_addr, mem_rd_data_width, mem_rd_format,
             out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, stride, len, data_width, format, mem_rd_data, out_ready,
      input  busy, done, mem_rd_en, mem_rd_addr, mem_rd_data_width, mem_rd_format,
             out_valid, out_data, out_last
   );
endinterface

// File: rtl/int_res_stream_rd.sv
// int_res_stream_rd: sequential strided reader of the int-res memory, returned words streamed out.
// Latency: start to first out_valid 3 cycles; one word per cycle sustained.
// Backpressure: 2-entry return FIFO; reads stall when FIFO + in-flight would exceed 2, resume on the pop cycle.
// Ports: i_clk, i_rst (sync, active-high); io_bus (master modport) carries job, memory read port and stream.
module int_res_stream_rd #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,   // N_COMP
   parameter int FMT_W  = 3,
   parameter int LEN_W  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   int_res_stream_rd_if.master   io_bus
);
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_stride;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_issue_rem;
   logic [LEN_W-1:0]    r_pop_cnt;
   logic                r_dw;
   logic [FMT_W-1:0]    r_fmt;
   logic                r_inflight;
   logic                r_done;
   logic [DATA_W-1:0]   r_fifo [2];
   logic                r_wr_ptr;
   logic                r_rd_ptr;
   logic [1:0]          r_count;

   logic                w_accept;
   logic                w_valid;
   logic                w_pop;
   logic                w_head_last;
   logic [2:0]          w_credit_use;
   logic                w_credit_ok;
   logic                w_issue;

   assign w_accept    = (r_state == S_IDLE) && io_bus.start;
   assign w_valid     = (r_count != 2'd0);
   assign w_pop       = w_valid && io_bus.out_ready;
   assign w_head_last = w_valid && (r_pop_cnt == r_len - LEN_W'(1));

   // Slots this cycle's read would compete for once it lands: FIFO content plus the
   // word on the return bus, minus the word leaving now. Including the same-cycle pop
   // is what lets a stalled stream restart reads in the very cycle it drains.
   assign w_credit_use = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_credit_ok  = (w_credit_use < 3'd2);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && (io_bus.len != '0))                  w_state_nxt = S_STREAM;
         S_STREAM: if (w_issue && (r_issue_rem == LEN_W'(1)))           w_state_nxt = S_FLUSH;
         S_FLUSH:  if (w_pop && w_head_last)                            w_state_nxt = S_IDLE;
         default:                                                       w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // mem_rd_addr and the job attributes come straight from registers; the enable
   // is qualified by the current cycle's credit so throughput stays at one per cycle.
   always_comb begin
      w_issue          = (r_state == S_STREAM) && (r_issue_rem != '0) && w_credit_ok;
      io_bus.mem_rd_en = w_issue;
      io_bus.busy      = (r_state != S_IDLE);
   end

   assign io_bus.done              = r_done;
   assign io_bus.mem_rd_addr       = r_addr;
   assign io_bus.mem_rd_data_width = r_dw;
   assign io_bus.mem_rd_format     = r_fmt;
   assign io_bus.out_valid         = w_valid;
   assign io_bus.out_data          = r_fifo[r_rd_ptr];
   assign io_bus.out_last          = w_head_last;

   // ---------------- job registers, address generation, return FIFO ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr      <= '0;
         r_stride    <= '0;
         r_len       <= '0;
         r_issue_rem <= '0;
         r_pop_cnt   <= '0;
         r_dw        <= 1'b0;
         r_fmt       <= '0;
         r_inflight  <= 1'b0;
         r_done      <= 1'b0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      end else begin
         // zero-length jobs complete straight from IDLE; others after the last pop
         r_done <= (w_accept && (io_bus.len == '0)) ||
                   ((r_state == S_FLUSH) && w_pop && w_head_last);

         if (w_accept) begin
            r_addr      <= io_bus.base_addr;
            r_stride    <= io_bus.stride;
            r_len       <= io_bus.len;
            r_issue_rem <= io_bus.len;
            r_dw        <= io_bus.data_width;
            r_fmt       <= io_bus.format;
            r_pop_cnt   <= '0;
         end else begin
            if (w_issue) begin
               r_addr      <= r_addr + r_stride;   // wraps modulo 2^ADDR_W
               r_issue_rem <= r_issue_rem - LEN_W'(1);
            end
            if (w_pop) r_pop_cnt <= r_pop_cnt + LEN_W'(1);
         end

         // memory returns data one cycle after the enable
         r_inflight <= w_issue;
         if (r_inflight) begin
            r_fifo[r_wr_ptr] <= io_bus.mem_rd_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end
endmodule
